ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter. It sends one command byte per handshake to the keyboard on the same PS/2 port that the existing keyboard receiver listens on, for example 0xED for the LED set command or 0xFF for reset. It drives the open-drain PS2 clock and data lines through active-high pull-low enables, and raises BUSY so the receiver ignores line activity while a host frame is in flight. It sits in the 25 MHz domain beside the PS/2 receiver inside topEntity.

## Interface
Parameters:
- INHIBIT_CYCLES, default 2600: clock-low inhibit time before the start bit (104 µs at 25 MHz).
- TIMEOUT_CYCLES, default 50000: maximum gap allowed between device clock falls, including the first one (2 ms).
- FILTER_LEN, default 4: number of consecutive equal synchronized samples needed to update a filtered line.

Ports:
- CLK_25MHZ, in, 1: the only clock.
- RESET_N, in, 1: reset, asynchronous, active-low.
- TX_VALID, in, 1: command byte offered.
- TX_DATA, in, 8: command byte.
- TX_READY, out, 1: block is idle and accepts a byte.
- PS2_CLK_IN, in, 1: raw PS2 clock line, asynchronous.
- PS2_DATA_IN, in, 1: raw PS2 data line, asynchronous.
- PS2_CLK_OE, out, 1: 1 pulls the PS2 clock line low.
- PS2_DATA_OE, out, 1: 1 pulls the PS2 data line low.
- BUSY, out, 1: a frame is in progress (any state other than IDLE).
- DONE, out, 1: one-cycle pulse when the device ACKs the frame.
- ERROR, out, 1: one-cycle pulse on NACK or timeout.

## Operation
- Input conditioning:
  - Each raw line passes through a 2-FF synchronizer and then the FILTER_LEN stability filter.
  - Filter outputs reset to 1.
  - A falling edge (fall) is a filtered clock transition from 1 to 0.
- Frame content: 11 device clocks. Data bits 0–7 (LSB first), odd parity, stop, ACK.
  - Parity = ~^TX_DATA. Example: 0xED has 6 ones, so parity = 1.
- States and transitions:
  - IDLE: all OE = 0 and TX_READY = 1. On TX_VALID & TX_READY, latch TX_DATA, compute parity, go to INHIBIT.
  - INHIBIT: PS2_CLK_OE = 1 for INHIBIT_CYCLES cycles, then go to START.
  - START: PS2_DATA_OE = 1 (start bit 0). One cycle later PS2_CLK_OE = 0. Go to SEND with bit counter = 0 and timeout counter cleared.
  - SEND: on each fall, drive the next bit and increment the counter.
    - Falls 1–8: data bit n-1.
    - Fall 9: parity.
    - Fall 10: stop bit; PS2_DATA_OE = 0 and stays 0.
    - OE = ~bit.
    - Fall 11 goes to ACK_SAMPLE.
  - ACK_SAMPLE: capture filtered data. 0 means ACK, 1 means NACK. Go to RELEASE.
  - RELEASE: wait until filtered clock and data are both 1. Then pulse DONE (ACK) or ERROR (NACK) and go to IDLE.
- Timeout:
  - In SEND, ACK_SAMPLE and RELEASE, a counter increments every cycle and clears on each fall.
  - If it reaches TIMEOUT_CYCLES: both OE = 0, pulse ERROR, go to IDLE. The frame is abandoned and no DONE is produced.
- TX_VALID while BUSY is ignored. The byte is not queued.
- TX_DATA is sampled only at acceptance. Later changes have no effect on the frame.

## Timing
- Reset values:
  - TX_READY = 1.
  - BUSY, DONE, ERROR, PS2_CLK_OE, PS2_DATA_OE = 0.
  - State = IDLE.
  - All counters = 0.
- Asserting RESET_N low mid-frame releases both lines immediately (asynchronously) and aborts with no DONE or ERROR pulse.
- Acceptance at cycle t:
  - t+1: TX_READY = 0, BUSY = 1, PS2_CLK_OE = 1.
  - t+1+INHIBIT_CYCLES: PS2_DATA_OE = 1.
  - One cycle later: PS2_CLK_OE = 0.
- A raw clock fall becomes a filtered fall 2 + FILTER_LEN cycles later. The matching OE update occurs in the following cycle, well inside the ≥5 µs device clock-low phase.
- DONE and ERROR are mutually exclusive and last exactly 1 cycle. TX_READY returns to 1 in the cycle after the pulse.
- A new TX_VALID may be accepted on the first cycle TX_READY = 1 (back-to-back frames are allowed).
- Filter glitch rule: a clock low shorter than FILTER_LEN cycles produces no fall and no bit advance.

## Test plan
- Send 0xED with a device model that clocks at 12.5 kHz and ACKs. Required response:
  - Data line shows 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Exactly one DONE pulse and no ERROR.
  - Clock held low for 2600 cycles before the start bit.
- Send 0x00 with the device NACKing (data high at clock 11). Required: parity 1, ERROR pulse once, no DONE, TX_READY back to 1.
- Device never clocks after the start bit. Required:
  - ERROR exactly 50000 cycles after the clock release.
  - Both OE = 0.
  - TX_READY = 1.
- Device stops after the 5th clock. Required: ERROR 50000 cycles after fall 5, and the lines are released.
- Assert RESET_N low during bit 4. Required: same cycle PS2_CLK_OE = 0 and PS2_DATA_OE = 0, no DONE or ERROR. After release, TX_READY = 1 and sending 0xFF completes with DONE.
- Glitch and busy checks:
  - Inject a 2-cycle clock low glitch mid-frame. Required: no bit advance, and 0xFF is still received correctly.
  - Hold TX_VALID while BUSY. Required: only one frame is sent.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device clock falls, then samples the device ACK and waits for both lines to be released.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2600,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       TX_VALID,
  input  logic [7:0] TX_DATA,
  output logic       TX_READY,
  input  logic       PS2_CLK_IN,
  input  logic       PS2_DATA_IN,
  output logic       PS2_CLK_OE,
  output logic       PS2_DATA_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERROR
);

  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_ACK_SAMPLE,
    S_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         clk_sync_q, clk_sync_d;
  logic [1:0]         data_sync_q, data_sync_d;
  logic               clk_filt_q, clk_filt_d;
  logic               data_filt_q, data_filt_d;
  logic [FLT_W-1:0]   clk_flt_cnt_q, clk_flt_cnt_d;
  logic [FLT_W-1:0]   data_flt_cnt_q, data_flt_cnt_d;
  logic               fall_q, fall_d;
  logic [INH_W-1:0]   inh_cnt_q, inh_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
  logic [8:0]         frame_q, frame_d;
  logic               nack_q, nack_d;
  logic               clk_oe_q, clk_oe_d;
  logic               data_oe_q, data_oe_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               tx_ready;
  logic               timed_state;
  logic               timeout_hit;

  // Synchronizers and stability filters; idle bus level is high.
  always_comb begin
    clk_sync_d     = {clk_sync_q[0], PS2_CLK_IN};
    data_sync_d    = {data_sync_q[0], PS2_DATA_IN};
    clk_filt_d     = clk_filt_q;
    clk_flt_cnt_d  = '0;
    data_filt_d    = data_filt_q;
    data_flt_cnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (clk_flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        clk_filt_d = clk_sync_q[1];
      end else begin
        clk_flt_cnt_d = clk_flt_cnt_q + 1'b1;
      end
    end
    if (data_sync_q[1] != data_filt_q) begin
      if (data_flt_cnt_q == FLT_W'(FILTER_LEN - 1)) begin
        data_filt_d = data_sync_q[1];
      end else begin
        data_flt_cnt_d = data_flt_cnt_q + 1'b1;
      end
    end
    fall_d = clk_filt_q & ~clk_filt_d;
  end

  // The ready pulse cycle is excluded so TX_READY rises the cycle after DONE/ERROR.
  assign tx_ready    = (state_q == S_IDLE) && !done_q && !error_q;
  assign timed_state = (state_q == S_SEND) || (state_q == S_ACK_SAMPLE) || (state_q == S_RELEASE);
  assign timeout_hit = timed_state && !fall_q && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    bit_cnt_d = bit_cnt_q;
    to_cnt_d  = to_cnt_q;
    frame_d   = frame_q;
    nack_d    = nack_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    // A fall loads 1 so the counter equals cycles elapsed since that fall.
    if (timed_state) begin
      to_cnt_d = fall_q ? TO_W'(1) : to_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (TX_VALID && tx_ready) begin
          frame_d   = {~^TX_DATA, TX_DATA};
          inh_cnt_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == INH_W'(INHIBIT_CYCLES - 1)) begin
          data_oe_d = 1'b1;
          state_d   = S_START;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
        end
      end
      S_START: begin
        clk_oe_d  = 1'b0;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fall_q) begin
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q < 4'd9) begin
            data_oe_d = ~frame_q[bit_cnt_q];
          end else if (bit_cnt_q == 4'd9) begin
            data_oe_d = 1'b0;
          end else begin
            state_d = S_ACK_SAMPLE;
          end
        end
      end
      S_ACK_SAMPLE: begin
        nack_d  = data_filt_q;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (clk_filt_q && data_filt_q) begin
          done_d    = ~nack_q;
          error_d   = nack_q;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (timeout_hit) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      error_d   = 1'b1;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge CLK_25MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q        <= S_IDLE;
      clk_sync_q     <= 2'b11;
      data_sync_q    <= 2'b11;
      clk_filt_q     <= 1'b1;
      data_filt_q    <= 1'b1;
      clk_flt_cnt_q  <= '0;
      data_flt_cnt_q <= '0;
      fall_q         <= 1'b0;
      inh_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      to_cnt_q       <= '0;
      frame_q        <= '0;
      nack_q         <= 1'b0;
      clk_oe_q       <= 1'b0;
      data_oe_q      <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      clk_sync_q     <= clk_sync_d;
      data_sync_q    <= data_sync_d;
      clk_filt_q     <= clk_filt_d;
      data_filt_q    <= data_filt_d;
      clk_flt_cnt_q  <= clk_flt_cnt_d;
      data_flt_cnt_q <= data_flt_cnt_d;
      fall_q         <= fall_d;
      inh_cnt_q      <= inh_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      to_cnt_q       <= to_cnt_d;
      frame_q        <= frame_d;
      nack_q         <= nack_d;
      clk_oe_q       <= clk_oe_d;
      data_oe_q      <= data_oe_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign TX_READY    = tx_ready;
  assign BUSY        = (state_q != S_IDLE);
  assign PS2_CLK_OE  = clk_oe_q;
  assign PS2_DATA_OE = data_oe_q;
  assign DONE        = done_q;
  assign ERROR       = error_q;

endmodule
